// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes,
// ALU operation codes and the packed control-output bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       PCWrite;
    logic       Branch;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [1:0] ALUOp;
    logic       InstrDone;
    logic       IllegalOp;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// State-to-control decode. Purely combinational; takes the raw 4-bit state
// code so the unused codes 12-15 decode to all-zero outputs.
module mc_outdec
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output ctrl_t      ctrl
);

  // Every field defaults to zero; each state raises only what it needs.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ALUSrcB = SRCB_FOUR;
        ctrl.IRWrite = MemReady;
        ctrl.PCWrite = MemReady;
      end
      S_DECODE: begin
        ctrl.ALUSrcB = SRCB_IMM2;
        if (!op_legal(Op)) begin
          ctrl.IllegalOp = 1'b1;
          ctrl.InstrDone = 1'b1;
        end
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.MemtoReg  = 1'b1;
        ctrl.RegWrite  = 1'b1;
        ctrl.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        ctrl.IorD      = 1'b1;
        ctrl.MemWrite  = 1'b1;
        ctrl.InstrDone = MemReady;
      end
      S_EXECUTE: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.RegDst    = 1'b1;
        ctrl.RegWrite  = 1'b1;
        ctrl.InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl.ALUSrcA   = 1'b1;
        ctrl.ALUOp     = ALUOP_SUB;
        ctrl.PCSrc     = PCSRC_OUT;
        ctrl.Branch    = 1'b1;
        ctrl.InstrDone = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.RegWrite  = 1'b1;
        ctrl.InstrDone = 1'b1;
      end
      S_JUMP: begin
        ctrl.PCSrc     = PCSRC_JUMP;
        ctrl.PCWrite   = 1'b1;
        ctrl.InstrDone = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller: state register and next-state logic.
// Output decode lives in mc_outdec.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t state, state_nx;
  ctrl_t  ctrl;

  // State register; reset forces FETCH immediately, aborting any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next-state; memory states hold until MemReady with no bound.
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:   state_nx = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_EXECUTE;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nx = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nx = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_nx = S_FETCH;
      S_MEMWR:   state_nx = MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_nx = S_ALUWB;
      S_ALUWB:   state_nx = S_FETCH;
      S_BRANCH:  state_nx = S_FETCH;
      S_ADDIEX:  state_nx = S_ADDIWB;
      S_ADDIWB:  state_nx = S_FETCH;
      S_JUMP:    state_nx = S_FETCH;
      default:   state_nx = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state    (state),
    .Op       (Op),
    .MemReady (MemReady),
    .ctrl     (ctrl)
  );

  assign State     = state;
  assign ALUOp     = ctrl.ALUOp;
  assign PCWrite   = ctrl.PCWrite;
  assign Branch    = ctrl.Branch;
  assign IorD      = ctrl.IorD;
  assign MemRead   = ctrl.MemRead;
  assign MemWrite  = ctrl.MemWrite;
  assign IRWrite   = ctrl.IRWrite;
  assign RegDst    = ctrl.RegDst;
  assign MemtoReg  = ctrl.MemtoReg;
  assign RegWrite  = ctrl.RegWrite;
  assign ALUSrcA   = ctrl.ALUSrcA;
  assign ALUSrcB   = ctrl.ALUSrcB;
  assign PCSrc     = ctrl.PCSrc;
  assign InstrDone = ctrl.InstrDone;
  assign IllegalOp = ctrl.IllegalOp;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control, plus hand-written
// reset-mid-stall sequence and a direct check of unused state codes.
module tb_multicycle_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       MemReady;
  logic [1:0] ALUOp, ALUSrcB, PCSrc;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, InstrDone, IllegalOp;
  logic [3:0] State;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
    .ALUOp(ALUOp), .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp), .State(State)
  );

  // Second decoder instance to reach the unused codes 12-15.
  logic [3:0] ud_state;
  ctrl_t      ud_ctrl;
  mc_outdec u_dec_chk (.state(ud_state), .Op(Op), .MemReady(1'b1), .ctrl(ud_ctrl));

  // Order: PCWrite Branch IorD MemRead MemWrite IRWrite RegDst MemtoReg
  //        RegWrite ALUSrcA | ALUSrcB | PCSrc | ALUOp | InstrDone IllegalOp
  logic [17:0] act;
  assign act = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
                InstrDone, IllegalOp};

  localparam logic [17:0] F1   = {10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] F0   = {10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] DEC  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] DECI = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b11};
  localparam logic [17:0] MADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] MRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] MWB  = {10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] MWR0 = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] MWR1 = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] EXE  = {10'b0000000001, 2'b00, 2'b00, 2'b10, 2'b00};
  localparam logic [17:0] AWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] BR   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [17:0] AIWB = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] JMP  = {10'b1000000000, 2'b00, 2'b10, 2'b00, 2'b10};

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [17:0] ctl);
    vec_t v;
    v.tag = tag; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one vector at the falling edge and check before the next rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    Op = v.op;
    MemReady = v.mr;
    #1;
    check({v.tag, " state"}, 32'(State), 32'(v.st));
    check({v.tag, " ctrl"},  32'(act),   32'(v.ctl));
  endtask

  initial begin
    rst_n = 1'b0; Op = 6'd0; MemReady = 1'b0; ud_state = 4'd0;

    // Reset state without any clock edge.
    #1;
    check("reset state", 32'(State), 32'd0);
    check("reset ctrl mr0", 32'(act), 32'(F0));
    MemReady = 1'b1; #1;
    check("reset ctrl mr1", 32'(act), 32'(F1));
    @(negedge clk);
    MemReady = 1'b0;
    rst_n = 1'b1;

    // lw, no stalls: 5 cycles
    add("lw0", OP_LW, 1, 0, F1);   add("lw1", OP_LW, 1, 1, DEC);
    add("lw2", OP_LW, 1, 2, MADR); add("lw3", OP_LW, 1, 3, MRD);
    add("lw4", OP_LW, 1, 4, MWB);
    // sw, three stall cycles in MEMWR
    add("sw0", OP_SW, 1, 0, F1);   add("sw1", OP_SW, 1, 1, DEC);
    add("sw2", OP_SW, 1, 2, MADR);
    add("sw3", OP_SW, 0, 5, MWR0); add("sw4", OP_SW, 0, 5, MWR0);
    add("sw5", OP_SW, 0, 5, MWR0); add("sw6", OP_SW, 1, 5, MWR1);
    // R-type
    add("r0", OP_RTYPE, 1, 0, F1); add("r1", OP_RTYPE, 1, 1, DEC);
    add("r2", OP_RTYPE, 1, 6, EXE); add("r3", OP_RTYPE, 1, 7, AWB);
    // beq, j
    add("beq0", OP_BEQ, 1, 0, F1); add("beq1", OP_BEQ, 1, 1, DEC);
    add("beq2", OP_BEQ, 1, 8, BR);
    add("j0", OP_J, 1, 0, F1);     add("j1", OP_J, 1, 1, DEC);
    add("j2", OP_J, 1, 11, JMP);
    // addi
    add("ai0", OP_ADDI, 1, 0, F1); add("ai1", OP_ADDI, 1, 1, DEC);
    add("ai2", OP_ADDI, 1, 9, MADR); add("ai3", OP_ADDI, 1, 10, AIWB);
    // illegal opcode: 2 cycles
    add("ill0", 6'b111111, 1, 0, F1); add("ill1", 6'b111111, 1, 1, DECI);
    // fetch stall, then lw with a MEMRD stall
    add("fs0", OP_LW, 0, 0, F0);   add("fs1", OP_LW, 0, 0, F0);
    add("fs2", OP_LW, 1, 0, F1);   add("fs3", OP_LW, 1, 1, DEC);
    add("fs4", OP_LW, 1, 2, MADR); add("fs5", OP_LW, 0, 3, MRD);
    add("fs6", OP_LW, 1, 3, MRD);  add("fs7", OP_LW, 1, 4, MWB);
    add("end0", OP_SW, 1, 0, F1);  add("end1", OP_SW, 1, 1, DEC);
    add("end2", OP_SW, 1, 2, MADR); add("end3", OP_SW, 0, 5, MWR0);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset asserted mid-MEMWR stall: immediate return to FETCH.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid-stall state", 32'(State), 32'd0);
    check("rst mid-stall MemWrite", 32'(MemWrite), 32'd0);
    check("rst mid-stall ctrl", 32'(act), 32'(F0));
    @(negedge clk);
    #1;
    check("rst held state", 32'(State), 32'd0);
    MemReady = 1'b1;
    rst_n = 1'b1;
    Op = OP_J;
    // First edge after release is evaluated as FETCH -> DECODE.
    @(negedge clk); #1;
    check("post-rst state", 32'(State), 32'd1);
    check("post-rst ctrl", 32'(act), 32'(DEC));
    @(negedge clk); #1;
    check("post-rst jump", 32'(State), 32'd11);

    // Unused state codes decode to all-zero outputs.
    for (int c = 12; c < 16; c++) begin
      ud_state = 4'(c);
      #1;
      check($sformatf("unused code %0d", c), 32'(ud_ctrl), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
